// File: rtl/pipe_bp_pkg.sv
// Shared constants for the pipe branch predictor.
// Two-bit direction counter encodings and their reset/allocate values.
package pipe_bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_RST   = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

endpackage

// File: rtl/pipe_bp_counter.sv
// Two-bit saturating direction counter next-state function.
// Moves toward ST on taken, toward SNT otherwise.
module pipe_bp_counter
  import pipe_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/pipe_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the IF stage.
// Trained from ID; keeps saturating branch/mispredict statistics.
module pipe_branch_predictor
  import pipe_bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  n_branches,
  output logic [CNT_W-1:0]  n_mispred
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int N     = 1 << INDEX_W;

  logic              valid_q [N];
  logic [1:0]        ctr_q   [N];
  logic [TAG_W-1:0]  tag_q   [N];
  logic [ADDR_W-1:0] tgt_q   [N];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] uidx;
  logic [TAG_W-1:0]   utag;
  logic               uhit;
  logic [1:0]         ctr_nxt;
  logic               mispred;
  logic               unused_lsbs;

  assign idx  = pc[INDEX_W+1:2];
  assign tag  = pc[ADDR_W-1:INDEX_W+2];
  assign uidx = upd_pc[INDEX_W+1:2];
  assign utag = upd_pc[ADDR_W-1:INDEX_W+2];

  assign unused_lsbs = ^{pc[1:0], upd_pc[1:0]};

  assign pred_hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign pred_taken  = pred_hit && ctr_q[idx][1];
  assign pred_target = pred_taken ? tgt_q[idx] : pc + ADDR_W'(4);

  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  assign mispred = (upd_pred_taken != upd_taken) ||
                   (upd_taken && upd_pred_taken &&
                    (upd_pred_target != upd_target));

  pipe_bp_counter u_ctr (
    .ctr   (ctr_q[uidx]),
    .taken (upd_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (upd_en) begin
      if (uhit) begin
        ctr_q[uidx] <= ctr_nxt;
      end else if (upd_taken) begin
        valid_q[uidx] <= 1'b1;
        ctr_q[uidx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag/target need no reset: valid gates every use of them.
  always_ff @(posedge clock) begin
    if (resetn && !flush && upd_en && upd_taken) begin
      tag_q[uidx] <= utag;
      tgt_q[uidx] <= upd_target;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || clr_stats) begin
      n_branches <= '0;
      n_mispred  <= '0;
    end else if (upd_en && !flush) begin
      if (n_branches != '1) n_branches <= n_branches + CNT_W'(1);
      if (mispred && n_mispred != '1) n_mispred <= n_mispred + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_branch_predictor.sv
// Directed self-checking bench for pipe_branch_predictor.
// Uses CNT_W=4 so statistics saturation is reachable quickly.
module tb_pipe_branch_predictor;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 4;
  localparam int CNT_W   = 4;

  logic              clock = 1'b0;
  logic              resetn;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_hit;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              flush;
  logic              clr_stats;
  logic [CNT_W-1:0]  n_branches;
  logic [CNT_W-1:0]  n_mispred;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_branch_predictor #(
    .ADDR_W  (ADDR_W),
    .INDEX_W (INDEX_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_hit        (pred_hit),
    .upd_en          (upd_en),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .clr_stats       (clr_stats),
    .n_branches      (n_branches),
    .n_mispred       (n_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] a,
                      input logic h, input logic t,
                      input logic [31:0] tgt);
    pc = a;
    #1;
    chk({tag, "_hit"}, 32'(pred_hit), 32'(h));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic stats(input string tag, input int b, input int m);
    chk({tag, "_nbr"}, 32'(n_branches), 32'(b));
    chk({tag, "_nmis"}, 32'(n_mispred), 32'(m));
  endtask

  task automatic upd(input logic [31:0] a, input logic t,
                     input logic [31:0] tgt, input logic pt,
                     input logic [31:0] ptgt);
    upd_en = 1'b1;
    upd_pc = a;
    upd_taken = t;
    upd_target = tgt;
    upd_pred_taken = pt;
    upd_pred_target = ptgt;
    @(posedge clock);
    #1;
    upd_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    pc = '0;
    upd_en = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    flush = 1'b0;
    clr_stats = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    stats("rst", 0, 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    look("post_rst", 32'h40, 1'b0, 1'b0, 32'h44);
    stats("post_rst", 0, 0);

    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    stats("alloc", 1, 1);

    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    look("wnt", 32'h40, 1'b1, 1'b0, 32'h44);
    stats("wnt", 2, 2);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    look("wt", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    look("st", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    look("st_hold", 32'h40, 1'b1, 1'b1, 32'h100);
    stats("st_hold", 5, 3);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    look("st_dec", 32'h40, 1'b1, 1'b1, 32'h100);
    stats("st_dec", 6, 4);

    upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
    look("evicted", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias", 32'h440, 1'b1, 1'b1, 32'h200);
    stats("alias", 7, 5);
    upd(32'h440, 1'b1, 32'h300, 1'b1, 32'h200);
    look("retarget", 32'h440, 1'b1, 1'b1, 32'h300);
    stats("retarget", 8, 6);
    upd(32'h84, 1'b0, 32'h0, 1'b0, 32'h0);
    look("miss_nt", 32'h84, 1'b0, 1'b0, 32'h88);
    stats("miss_nt", 9, 6);

    upd_en = 1'b1;
    upd_pc = 32'h80;
    upd_taken = 1'b1;
    upd_target = 32'h500;
    upd_pred_taken = 1'b0;
    upd_pred_target = 32'h0;
    look("same_cyc", 32'h80, 1'b0, 1'b0, 32'h84);
    @(posedge clock);
    #1;
    upd_en = 1'b0;
    look("next_cyc", 32'h80, 1'b1, 1'b1, 32'h500);
    stats("next_cyc", 10, 7);

    flush = 1'b1;
    upd(32'hC0, 1'b1, 32'h600, 1'b0, 32'h0);
    flush = 1'b0;
    look("fl_80", 32'h80, 1'b0, 1'b0, 32'h84);
    look("fl_440", 32'h440, 1'b0, 1'b0, 32'h444);
    look("fl_c0", 32'hC0, 1'b0, 1'b0, 32'hC4);
    stats("flush", 10, 7);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    upd(32'h80, 1'b1, 32'h500, 1'b0, 32'h0);
    look("realloc", 32'h80, 1'b1, 1'b1, 32'h500);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    look("mid_rst", 32'h80, 1'b0, 1'b0, 32'h84);
    stats("mid_rst", 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    end
    stats("sat", 15, 15);

    clr_stats = 1'b1;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    clr_stats = 1'b0;
    stats("clr", 0, 0);
    look("clr_tbl", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    stats("after_clr", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_branch_predictor.md
Name: pipe_branch_predictor

Overview:
Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the 5-stage pipe computer.
- Sits beside the IF stage. It looks up the current pc in the same cycle and supplies a predicted next pc.
- It is trained by the branch-resolving stage (ID) through an update port.
- It replaces the fixed predict-not-taken behaviour of the current pipeline. Depth, address width and statistics counters are configurable.

Parameters:
ADDR_W, 32, pc/target width in bits; instructions are word aligned, so pc[1:0] are ignored.
INDEX_W, 4, log2 of entry count (16 entries by default); range 1..10.
CNT_W, 16, width of the performance counters.
TAG_W (localparam), ADDR_W-INDEX_W-2, tag width.

Ports:
clock  in  1  system clock; all state changes on its rising edge
resetn  in  1  synchronous active-low reset, sampled on the rising edge of clock
pc  in  ADDR_W  IF-stage fetch address
pred_taken  out  1  lookup hit and counter predicts taken
pred_target  out  ADDR_W  predicted next pc: stored target if pred_taken, else pc+4
pred_hit  out  1  valid entry with matching tag
upd_en  in  1  a branch/jump resolved this cycle
upd_pc  in  ADDR_W  address of the resolved instruction
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target (bpc/jpc)
upd_pred_taken  in  1  direction that was predicted for this instruction
upd_pred_target  in  ADDR_W  target that was predicted for this instruction
flush  in  1  invalidate the whole table
clr_stats  in  1  zero both performance counters
n_branches  out  CNT_W  resolved-branch count, saturating
n_mispred  out  CNT_W  misprediction count, saturating

Behaviour:
- Indexing: idx = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2]. The update port uses the same split on upd_pc.
- Per-entry storage: valid, tag, target, ctr[1:0].
- Counter encodings: 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST).
- Lookup is purely combinational from the current table contents; zero latency.
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : pc+4, computed modulo 2^ADDR_W; wrap at the top of the address space is allowed.
- Update on a rising edge with upd_en=1:
  - Hit (valid and tag match): ctr increments if upd_taken, else decrements. It saturates at 11 and 00 respectively.
  - Hit and taken: target is overwritten with upd_target.
  - Miss and taken: allocate the entry. valid=1, tag and target written, ctr=10 (WT). Any previous entry at that index is evicted.
  - Miss and not taken: no table change.
- Misprediction, evaluated under upd_en: mispredict = (upd_pred_taken != upd_taken) || (upd_taken && upd_pred_taken && upd_pred_target != upd_target).
- Statistics:
  - n_branches increments on every upd_en.
  - n_mispred increments when mispredict is true.
  - Both saturate at all-ones and never wrap.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The write becomes visible from the next cycle.
- Priority on a clock edge:
  - resetn=0 outranks everything. All valid bits clear, all ctr values go to 01, counters go to 0. tag/target contents are don't-care.
  - flush=1: all valid bits clear and ctr values go to 01 in one cycle. The update port is ignored that cycle. Statistics are kept.
  - clr_stats=1: counters go to 0. A same-cycle upd_en is not counted. Table updates still apply.
- Output values while resetn=0, and in the cycle after reset: pred_hit=0, pred_taken=0, pred_target=pc+4, n_branches=0, n_mispred=0.
- Reset asserted mid-operation discards all learned state on that edge; there is no partial retention.
- upd_en=0: no state changes, other than flush and clr_stats.

Decomposition:
- Shared package pipe_bp_pkg holds:
  - counter encoding constants SNT/WNT/WT/ST;
  - reset counter value WNT;
  - allocation value WT.
- One natural sub-module: pipe_bp_counter. It is the 2-bit saturating next-state function (inputs ctr, taken; output next ctr), instantiated once on the update path.
- Table arrays and statistics stay in the top module.

Test Plan:
1. Reset then lookup pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044; n_branches=0, n_mispred=0.
2. Allocation: update upd_pc=0x40, taken=1, target=0x100, pred_taken=0. Next cycle lookup pc=0x40 -> hit=1, pred_taken=1, pred_target=0x100; n_branches=1, n_mispred=1.
3. Hysteresis: with the entry from test 2 at WT, send not-taken (ctr 01, lookup predicts not-taken, target 0x44). Then send taken (ctr back to 10). Then taken twice (ctr 11, held at 11) -> lookup pred_taken=1 after each taken update.
4. Alias/eviction (INDEX_W=4): after test 2, update pc=0x440 taken, target 0x200 -> lookup 0x40 hit=0; lookup 0x440 predicts 0x200.
5. Same-cycle hazard plus flush: update and lookup pc=0x80 in the same cycle -> old result (hit=0) that cycle, hit=1 next cycle. Then assert flush with upd_en=1 -> every lookup misses afterwards, that update is ignored, and statistics are unchanged.
6. Saturation with CNT_W=4: 20 mispredicted updates -> n_branches=15, n_mispred=15. Then clr_stats with upd_en=1 -> both 0.
